// File: rtl/pir_alarm_ctrl.sv
// PIR motion alarm controller: per-channel threshold debounce, an armed/alarm FSM with
// a buzzer timer and sticky trigger LEDs, and a small first-word-fall-through event log
// recording why each alarm ended and which channels fired.
module pir_alarm_ctrl #(
    parameter int unsigned NUM_SENSORS = 3,
    parameter int unsigned SAMPLE_W    = 7,
    parameter int unsigned THRESHOLD   = 50,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned BUZZ_CYCLES = 100,
    parameter int unsigned LOG_DEPTH   = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 arm_i,
    input  logic                                 stop_alarm_i,
    input  logic [NUM_SENSORS*SAMPLE_W-1:0]      sensor_data_i,
    output logic [NUM_SENSORS-1:0]               led_o,
    output logic                                 buzzer_o,
    output logic [$clog2(NUM_SENSORS+1)-1:0]     trig_count_o,
    input  logic                                 log_rd_en_i,
    output logic [NUM_SENSORS:0]                 log_rd_data_o,
    output logic                                 log_empty_o,
    output logic                                 log_full_o,
    output logic [7:0]                           log_ovf_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
    localparam int unsigned TmrW = $clog2(BUZZ_CYCLES + 1);
    localparam int unsigned TcW  = $clog2(NUM_SENSORS + 1);
    localparam int unsigned PtrW = $clog2(LOG_DEPTH);
    localparam int unsigned LogW = NUM_SENSORS + 1;

    localparam logic [SAMPLE_W-1:0] Thr     = SAMPLE_W'(THRESHOLD);
    localparam logic [CntW-1:0]     CntFull = CntW'(DEBOUNCE);
    localparam logic [TmrW-1:0]     TmrLast = TmrW'(BUZZ_CYCLES - 1);

    typedef enum logic [1:0] {
        StDisarmed,
        StIdle,
        StAlarm,
        StClear
    } state_e;

    state_e                 state_q;
    logic [NUM_SENSORS-1:0] hot;
    logic [NUM_SENSORS-1:0] led_q;
    logic                   buzzer_q;
    logic [TcW-1:0]         tc_q;
    logic [TmrW-1:0]        timer_q;

    // ------------------------------------------------------------------
    // Per-channel debounce
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_chan
        logic [SAMPLE_W-1:0] sample;
        logic [CntW-1:0]     cnt_q, cnt_d;
        logic                hot_q;

        assign sample = sensor_data_i[g*SAMPLE_W +: SAMPLE_W];
        assign hot[g] = hot_q;

        // Count consecutive above-threshold cycles; frozen at zero while disarmed.
        always_comb begin
            if (state_q == StDisarmed || sample < Thr) begin
                cnt_d = '0;
            end else if (cnt_q == CntFull) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Counter and registered hot flag.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                hot_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                hot_q <= (cnt_d == CntFull);
            end
        end
    end

    // ------------------------------------------------------------------
    // Alarm FSM
    // ------------------------------------------------------------------
    function automatic logic [TcW-1:0] popcnt(input logic [NUM_SENSORS-1:0] v);
        logic [TcW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            n = n + TcW'(v[i]);
        end
        return n;
    endfunction

    logic                   timer_done;
    logic                   alarm_end;
    logic [NUM_SENSORS-1:0] led_sticky;
    logic                   log_wr;
    logic [LogW-1:0]        log_wdata;

    // stop_alarm wins over timer expiry, so cause is simply the stop input.
    always_comb begin
        timer_done = (timer_q == TmrLast);
        alarm_end  = (state_q == StAlarm) && (stop_alarm_i || timer_done);
        led_sticky = led_q | hot;
        log_wr     = arm_i && alarm_end;
        log_wdata  = {stop_alarm_i, led_sticky};
    end

    // State transitions with registered led/buzzer/trig_count/timer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StDisarmed;
            led_q    <= '0;
            buzzer_q <= 1'b0;
            tc_q     <= '0;
            timer_q  <= '0;
        end else if (!arm_i) begin
            state_q  <= StDisarmed;
            led_q    <= '0;
            buzzer_q <= 1'b0;
            tc_q     <= '0;
            timer_q  <= '0;
        end else begin
            unique case (state_q)
                StDisarmed: begin
                    state_q <= StIdle;
                end
                StIdle: begin
                    if (|hot) begin
                        state_q  <= StAlarm;
                        led_q    <= hot;
                        tc_q     <= popcnt(hot);
                        buzzer_q <= 1'b1;
                        timer_q  <= '0;
                    end
                end
                StAlarm: begin
                    if (alarm_end) begin
                        state_q  <= StClear;
                        led_q    <= '0;
                        tc_q     <= '0;
                        buzzer_q <= 1'b0;
                        timer_q  <= '0;
                    end else begin
                        led_q   <= led_sticky;
                        tc_q    <= popcnt(led_sticky);
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StClear: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StDisarmed;
                end
            endcase
        end
    end

    assign led_o        = led_q;
    assign buzzer_o     = buzzer_q;
    assign trig_count_o = tc_q;

    // ------------------------------------------------------------------
    // Event log FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [LogW-1:0] mem_q [LOG_DEPTH];
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]      ovf_q;
    logic            empty, full, pop, push, drop;

    // A full FIFO still accepts a write when the same cycle frees a slot.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        pop   = log_rd_en_i && !empty;
        push  = log_wr && (!full || pop);
        drop  = log_wr && full && !pop;
    end

    // Pointers and overflow counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop && ovf_q != 8'hFF) begin
                ovf_q <= ovf_q + 1'b1;
            end
        end
    end

    // Storage; contents are only visible through the empty-gated read port.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= log_wdata;
        end
    end

    assign log_rd_data_o = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];
    assign log_empty_o   = empty;
    assign log_full_o    = full;
    assign log_ovf_o     = ovf_q;

endmodule

// File: tb/tb_pir_alarm_ctrl.sv
// Self-checking bench for pir_alarm_ctrl with default parameters.
module tb_pir_alarm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        rd_en = 1'b0;
    logic [20:0] sens = '0;
    logic [2:0]  led;
    logic        buzzer;
    logic [1:0]  tc;
    logic [3:0]  rdata;
    logic        empty, full;
    logic [7:0]  ovf;

    always #5 clk = ~clk;

    pir_alarm_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .arm_i         (arm),
        .stop_alarm_i  (stop),
        .sensor_data_i (sens),
        .led_o         (led),
        .buzzer_o      (buzzer),
        .trig_count_o  (tc),
        .log_rd_en_i   (rd_en),
        .log_rd_data_o (rdata),
        .log_empty_o   (empty),
        .log_full_o    (full),
        .log_ovf_o     (ovf)
    );

    typedef struct {
        logic        rst_n;
        logic        arm;
        logic        stop;
        logic        rd;
        logic [20:0] sens;
        int          cycles;
        logic        buz;
        logic [2:0]  led;
        logic [1:0]  tc;
        logic        empty;
        logic        full;
        logic [7:0]  ovf;
        logic [3:0]  rdata;
    } vec_t;

    localparam logic [20:0] Z = '0;

    vec_t       tbl[$];
    vec_t       exp_q[$];
    logic [3:0] fm[$];
    int         ovf_m = 0;
    int         checks = 0;
    int         failures = 0;
    int         vec_id = 0;
    string      phase = "init";

    function automatic logic [20:0] s3(input int c0, input int c1, input int c2);
        return {7'(c2), 7'(c1), 7'(c0)};
    endfunction

    function automatic vec_t mk(input int r, input int a, input int st, input int rd,
                                input logic [20:0] s, input int cyc, input int b,
                                input int l, input int t, input int e, input int f,
                                input int o, input int d);
        vec_t v;
        v.rst_n = 1'(r);  v.arm = 1'(a);  v.stop = 1'(st); v.rd = 1'(rd);
        v.sens = s;       v.cycles = cyc;
        v.buz = 1'(b);    v.led = 3'(l);  v.tc = 2'(t);
        v.empty = 1'(e);  v.full = 1'(f); v.ovf = 8'(o);   v.rdata = 4'(d);
        return v;
    endfunction

    function automatic int m_empty();
        return (fm.size() == 0) ? 1 : 0;
    endfunction

    function automatic int m_full();
        return (fm.size() == 8) ? 1 : 0;
    endfunction

    function automatic int m_front();
        return (fm.size() != 0) ? int'(fm[0]) : 0;
    endfunction

    // Drive a vector, queue its expectation, run the cycles, then compare.
    task automatic apply(input vec_t v);
        vec_t e;
        rst_n = v.rst_n;
        arm   = v.arm;
        stop  = v.stop;
        rd_en = v.rd;
        sens  = v.sens;
        exp_q.push_back(v);
        repeat (v.cycles) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({buzzer, led, tc, empty, full, ovf, rdata} !==
            {e.buz, e.led, e.tc, e.empty, e.full, e.ovf, e.rdata}) begin
            failures++;
            $display("FAIL %s#%0d got buz=%b led=%b tc=%0d empty=%b full=%b ovf=%0d rd=%b want buz=%b led=%b tc=%0d empty=%b full=%b ovf=%0d rd=%b",
                     phase, vec_id, buzzer, led, tc, empty, full, ovf, rdata,
                     e.buz, e.led, e.tc, e.empty, e.full, e.ovf, e.rdata);
        end
        vec_id++;
    endtask

    // One full alarm on channel ch ended by stop, with the FIFO model tracking the entry.
    task automatic alarm_and_stop(input int ch, input int pop_at_stop);
        logic [20:0] hs;
        int          m;
        hs = '0;
        hs[7*ch +: 7] = 7'd60;
        m = 1 << ch;
        apply(mk(1, 1, 0, 0, hs, 4, 0, 0, 0, m_empty(), m_full(), ovf_m, m_front()));
        apply(mk(1, 1, 0, 0, Z, 1, 1, m, 1, m_empty(), m_full(), ovf_m, m_front()));
        if (pop_at_stop != 0) begin
            void'(fm.pop_front());
        end
        if (fm.size() < 8) begin
            fm.push_back(4'(8 | m));
        end else if (ovf_m < 255) begin
            ovf_m++;
        end
        apply(mk(1, 1, 1, pop_at_stop, Z, 1, 0, 0, 0, m_empty(), m_full(), ovf_m, m_front()));
        apply(mk(1, 1, 0, 0, Z, 1, 0, 0, 0, m_empty(), m_full(), ovf_m, m_front()));
    endtask

    initial begin
        // rst, arm, stop, rd, sens, cycles | buz, led, tc, empty, full, ovf, rdata
        tbl.push_back(mk(0, 0, 0, 0, Z,             2, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,             2, 0, 0, 0, 1, 0, 0, 0));
        // Single channel, full-length timeout.
        tbl.push_back(mk(1, 1, 0, 0, s3(0, 60, 0),  4, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,             1, 1, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,            98, 1, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,             1, 1, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,             1, 0, 0, 0, 0, 0, 0, 4'b0010));
        tbl.push_back(mk(1, 1, 0, 0, Z,             1, 0, 0, 0, 0, 0, 0, 4'b0010));
        tbl.push_back(mk(1, 1, 0, 1, Z,             1, 0, 0, 0, 1, 0, 0, 0));
        // Debounce: 3 above then below must not trigger; count restarts from zero.
        tbl.push_back(mk(1, 1, 0, 0, s3(60, 0, 0),  3, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, s3(40, 0, 0),  3, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, s3(60, 0, 0),  2, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,             3, 0, 0, 0, 1, 0, 0, 0));
        // Threshold edge: 49 is below, 50 is above.
        tbl.push_back(mk(1, 1, 0, 0, s3(49, 49, 49), 6, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, s3(50, 0, 0),  4, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,             1, 1, 1, 1, 1, 0, 0, 0));
        // Second channel joins mid-alarm, stop on the 20th alarm cycle.
        tbl.push_back(mk(1, 1, 0, 0, s3(0, 0, 60),  4, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,             1, 1, 5, 2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,            14, 1, 5, 2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, Z,             1, 0, 0, 0, 0, 0, 0, 4'b1101));
        tbl.push_back(mk(1, 1, 0, 0, Z,             1, 0, 0, 0, 0, 0, 0, 4'b1101));
        tbl.push_back(mk(1, 1, 0, 1, Z,             1, 0, 0, 0, 1, 0, 0, 0));
        // Still-hot channel re-triggers after CLEAR, then disarm aborts without logging.
        tbl.push_back(mk(1, 1, 0, 0, s3(0, 60, 0),  4, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, s3(0, 60, 0),  1, 1, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, s3(0, 60, 0),  1, 0, 0, 0, 0, 0, 0, 4'b1010));
        tbl.push_back(mk(1, 1, 0, 0, s3(0, 60, 0),  1, 0, 0, 0, 0, 0, 0, 4'b1010));
        tbl.push_back(mk(1, 1, 0, 0, s3(0, 60, 0),  1, 1, 2, 1, 0, 0, 0, 4'b1010));
        tbl.push_back(mk(1, 0, 0, 0, s3(0, 60, 0),  1, 0, 0, 0, 0, 0, 0, 4'b1010));
        tbl.push_back(mk(1, 0, 0, 1, Z,             1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, Z,             2, 0, 0, 0, 1, 0, 0, 0));

        phase = "table";
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Stop asserted in the same cycle the timer expires: one entry, cause=stop.
        phase = "stop_vs_timeout";
        apply(mk(1, 1, 0, 0, s3(60, 0, 0), 4, 0, 0, 0, 1, 0, 0, 0));
        apply(mk(1, 1, 0, 0, Z,  1, 1, 1, 1, 1, 0, 0, 0));
        apply(mk(1, 1, 0, 0, Z, 98, 1, 1, 1, 1, 0, 0, 0));
        apply(mk(1, 1, 0, 0, Z,  1, 1, 1, 1, 1, 0, 0, 0));
        apply(mk(1, 1, 1, 0, Z,  1, 0, 0, 0, 0, 0, 0, 4'b1001));
        apply(mk(1, 1, 0, 0, Z,  1, 0, 0, 0, 0, 0, 0, 4'b1001));
        apply(mk(1, 1, 0, 1, Z,  1, 0, 0, 0, 1, 0, 0, 0));

        // Nine alarms with no reads: eight stored, one dropped, oldest intact.
        phase = "log_fill";
        for (int k = 0; k < 9; k++) begin
            alarm_and_stop(k % 3, 0);
        end
        // Write and pop together while full.
        phase = "log_full_pop_write";
        alarm_and_stop(0, 1);
        // Drain and confirm order.
        phase = "log_drain";
        for (int k = 0; k < 8; k++) begin
            void'(fm.pop_front());
            apply(mk(1, 1, 0, 1, Z, 1, 0, 0, 0, m_empty(), m_full(), ovf_m, m_front()));
        end

        // Reset in the middle of an alarm: no log entry, overflow count cleared.
        phase = "reset_mid_alarm";
        apply(mk(1, 1, 0, 0, s3(0, 0, 60), 4, 0, 0, 0, 1, 0, ovf_m, 0));
        apply(mk(1, 1, 0, 0, Z, 1, 1, 4, 1, 1, 0, ovf_m, 0));
        apply(mk(1, 1, 0, 0, Z, 3, 1, 4, 1, 1, 0, ovf_m, 0));
        apply(mk(0, 1, 0, 0, Z, 1, 0, 0, 0, 1, 0, 0, 0));
        apply(mk(1, 1, 0, 0, Z, 2, 0, 0, 0, 1, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pir_alarm_ctrl.md
PIR_ALARM_CTRL -- requirements
Module: pir_alarm_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SENSORS, default 3, number of PIR channels (1..16).
REQ-002 The block SHALL have parameter SAMPLE_W, default 7, bits per sensor sample.
REQ-003 The block SHALL have parameter THRESHOLD, default 50, unsigned motion level; sample >= THRESHOLD is "above".
REQ-004 The block SHALL have parameter DEBOUNCE, default 4, consecutive above-cycles before a channel is "hot" (>=1).
REQ-005 The block SHALL have parameter BUZZ_CYCLES, default 100, alarm duration in clock cycles (>=1).
REQ-006 The block SHALL have parameter LOG_DEPTH, default 8, event-log entries (power of 2).
REQ-007 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-009 The block SHALL have port arm, input, 1; 1 = system armed, 0 = disarmed.
REQ-010 The block SHALL have port stop_alarm, input, 1, user acknowledge ending an alarm.
REQ-011 The block SHALL have port sensor_data, input, NUM_SENSORS*SAMPLE_W; channel i at bits [i*SAMPLE_W +: SAMPLE_W].
REQ-012 The block SHALL have port led, output, NUM_SENSORS, per-channel triggered indicator.
REQ-013 The block SHALL have port buzzer, output, 1; high while alarming.
REQ-014 The block SHALL have port trig_count, output, clog2(NUM_SENSORS+1), popcount of led.
REQ-015 The block SHALL have ports log_rd_en (input, 1), log_rd_data (output, NUM_SENSORS+1), log_empty (output, 1), log_full (output, 1), log_ovf (output, 8).

Function
REQ-016 Each channel SHALL hold a debounce counter: +1 per above-cycle, saturating at DEBOUNCE; cleared to 0 on any below-cycle; hot[i] = (counter == DEBOUNCE), registered.
REQ-017 Debounce counters SHALL be held at 0 in DISARMED and run in all other states.
REQ-018 The FSM SHALL have states DISARMED, IDLE, ALARM, CLEAR.
REQ-019 DISARMED -> IDLE when arm=1; IDLE -> ALARM on the cycle after any hot[i]=1 is registered.
REQ-020 arm=0 SHALL force DISARMED from any state next cycle, with highest priority, no log write.
REQ-021 On ALARM entry led SHALL load the hot mask; during ALARM led[i] SHALL be set (sticky) whenever hot[i]=1.
REQ-022 buzzer SHALL be 1 in every cycle the FSM is in ALARM and 0 otherwise.
REQ-023 A duration timer SHALL count ALARM cycles; after exactly BUZZ_CYCLES cycles in ALARM the FSM SHALL go to CLEAR.
REQ-024 stop_alarm=1 in ALARM SHALL go to CLEAR next cycle, taking priority over timer expiry in the same cycle.
REQ-025 CLEAR SHALL last one cycle: led=0, buzzer=0, timer=0, then IDLE; a still-hot channel re-triggers ALARM one cycle later.
REQ-026 On ALARM->CLEAR the block SHALL write log entry {cause, led mask}; cause=1 stop_alarm, 0 timeout.
REQ-027 The log SHALL be a first-word-fall-through FIFO: log_rd_data shows oldest entry when log_empty=0; log_rd_en pops.
REQ-028 log_rd_en when log_empty=1 SHALL be ignored; pointers wrap modulo LOG_DEPTH.
REQ-029 A write when full without a same-cycle pop SHALL be dropped and log_ovf incremented, saturating at 255.
REQ-030 A write and pop in the same cycle when full SHALL both succeed; occupancy unchanged.
REQ-031 trig_count SHALL equal popcount(led), registered alongside led.

Reset
REQ-032 rst_n=0 at a rising edge SHALL set state DISARMED, led=0, buzzer=0, trig_count=0, timer and debounce counters 0, FIFO empty, log_empty=1, log_full=0, log_ovf=0, log_rd_data=0.
REQ-033 Reset mid-alarm SHALL abort without log write; behaviour resumes from DISARMED.

Verification
REQ-034 arm=1, ch1=60 for 4 cycles then 0 -> ALARM 1 cycle after hot, buzzer=1 for 100 cycles, led=3'b010, trig_count=1, log entry {0,010}.
REQ-035 ch0=60 for 3 cycles then 40 -> no alarm, buzzer stays 0 (debounce).
REQ-036 In ALARM, ch2 becomes hot mid-alarm, stop_alarm at cycle 20 -> led=101, trig_count=2, CLEAR next cycle, log entry {1,101}.
REQ-037 Nine alarms without reads -> log_full=1 after 8, log_ovf=1, oldest entry intact; pop+write when full keeps log_full=1.
REQ-038 arm=0 during ALARM, and separately rst_n=0 during ALARM -> DISARMED next cycle, buzzer=0, led=0, no log write.
REQ-039 stop_alarm and timer expiry in same cycle -> single log entry with cause=1.
